// File: rtl/jtag_axi_scan_ctrl.sv
// Command-driven JTAG scan sequencer. Turns TAP_RESET / IR_SCAN / DR_SCAN
// commands into TCK/TMS/TDI sequences and returns captured TDO bits over a
// valid/ready response channel. TCK is derived from clk with a half-period
// of CLK_DIV cycles.
module jtag_axi_scan_ctrl #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned CLK_DIV = 2,
    localparam int unsigned LEN_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic [LEN_W-1:0]  step_q, step_d;
    logic              is_ir_q, is_ir_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              phase_end;
    logic              last_step;
    logic [LEN_W-1:0]  step_nx;
    logic [LEN_W-1:0]  len_m1;

    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign step_nx   = step_q + LEN_W'(1);
    assign len_m1    = len_q - LEN_W'(1);

    // Identify the final TCK step of the current scan phase.
    always_comb begin
        last_step = 1'b0;
        case (state_q)
            S_RST:   last_step = (step_q == LEN_W'(5));
            S_PRE:   last_step = (step_q == (is_ir_q ? LEN_W'(3) : LEN_W'(2)));
            S_SHIFT: last_step = (step_q == len_m1);
            S_POST:  last_step = (step_q == LEN_W'(1));
            default: last_step = 1'b0;
        endcase
    end

    // Next-state and datapath: command accept, TCK phase timing, pin sequencing.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        step_d     = step_q;
        is_ir_d    = is_ir_q;
        len_d      = len_q;
        sr_d       = sr_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    len_d   = cmd_len_i;
                    sr_d    = cmd_data_i;
                    cap_d   = '0;
                    step_d  = '0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    is_ir_d = (cmd_op_i == 2'd1);
                    if (cmd_op_i == 2'd0) begin
                        state_d = S_RST;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end else if ((cmd_op_i == 2'd3) || (cmd_len_i == '0) ||
                                 (cmd_len_i > LEN_W'(DATA_W))) begin
                        // Rejected: no TCK activity, pins keep their values.
                        state_d    = S_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        state_d = S_PRE;
                        tms_d   = 1'b1;
                        tdi_d   = 1'b0;
                    end
                end
            end

            S_RST, S_PRE, S_SHIFT, S_POST: begin
                if (!phase_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!tck_q) begin
                        // Rising TCK: TDO is stable since the previous falling edge.
                        tck_d = 1'b1;
                        if (state_q == S_SHIFT) begin
                            cap_d = (cap_q >> 1) | (DATA_W'(tdo_i) << len_m1);
                        end
                    end else begin
                        // End of step: TMS/TDI for the next step change with TCK falling.
                        tck_d  = 1'b0;
                        step_d = step_nx;
                        if (!last_step) begin
                            case (state_q)
                                S_RST:   tms_d = (step_nx != LEN_W'(5));
                                S_PRE:   tms_d = is_ir_q && (step_nx == LEN_W'(1));
                                S_SHIFT: begin
                                    tms_d = (step_nx == len_m1);
                                    tdi_d = sr_q[1];
                                    sr_d  = sr_q >> 1;
                                end
                                default: tms_d = 1'b0;
                            endcase
                        end else begin
                            step_d = '0;
                            case (state_q)
                                S_PRE: begin
                                    state_d = S_SHIFT;
                                    tms_d   = (len_q == LEN_W'(1));
                                    tdi_d   = sr_q[0];
                                end
                                S_SHIFT: begin
                                    state_d = S_POST;
                                    tms_d   = 1'b1;
                                    tdi_d   = 1'b0;
                                end
                                S_POST: begin
                                    state_d    = S_RESP;
                                    rsp_data_d = cap_q;
                                    rsp_err_d  = 1'b0;
                                end
                                default: begin
                                    state_d    = S_RESP;
                                    rsp_data_d = '0;
                                    rsp_err_d  = 1'b0;
                                end
                            endcase
                        end
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d    = S_IDLE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            step_q     <= '0;
            is_ir_q    <= 1'b0;
            len_q      <= '0;
            sr_q       <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            step_q     <= step_d;
            is_ir_q    <= is_ir_d;
            len_q      <= len_d;
            sr_q       <= sr_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign busy_o      = (state_q == S_RST) || (state_q == S_PRE) ||
                         (state_q == S_SHIFT) || (state_q == S_POST);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule
